// File: rtl/cache_pkg.sv
// Shared types and widths for the data cache controller.
// Imported by the controller, its interface and the counters.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD_REQ,
    MEM_RD_WAIT,
    FILL,
    MEM_WR_REQ,
    RESP
  } dc_state_e;

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side handshake bundle of the cache controller.
// master = controller view, slave = CPU/memory environment view.
interface dcache_ctrl_if;
  import cache_pkg::*;

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_we,
    input  cpu_addr, cpu_wdata,
    output cpu_req_ready, cpu_resp_valid,
    output cpu_rdata,
    output mem_req_valid, mem_req_we,
    output mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid,
    input  mem_rdata
  );

  modport slave (
    output cpu_req_valid, cpu_req_we,
    output cpu_addr, cpu_wdata,
    input  cpu_req_ready, cpu_resp_valid,
    input  cpu_rdata,
    input  mem_req_valid, mem_req_we,
    input  mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid,
    output mem_rdata
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Synchronous active-high reset clears it.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking data cache controller: one request in flight,
// write-through / write-allocate, combinational cache lookup.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dcache_ctrl_if.master     bus,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic              c_we,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_hit,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  dc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic accept;
  logic ld_hit;
  logic ld_miss;

  assign accept  = bus.cpu_req_valid && (state_q == IDLE);
  assign ld_hit  = accept && !bus.cpu_req_we && c_hit;
  assign ld_miss = accept && !bus.cpu_req_we && !c_hit;

  // data_q holds store data or fill data; rdata_q is the CPU-visible value
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = bus.cpu_addr;
          if (bus.cpu_req_we) begin
            data_d  = bus.cpu_wdata;
            state_d = MEM_WR_REQ;
          end else if (c_hit) begin
            rdata_d = c_rdata;
            state_d = RESP;
          end else begin
            state_d = MEM_RD_REQ;
          end
        end
      end
      MEM_RD_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = MEM_RD_WAIT;
        end
      end
      MEM_RD_WAIT: begin
        if (bus.mem_resp_valid) begin
          data_d  = bus.mem_rdata;
          rdata_d = bus.mem_rdata;
          state_d = FILL;
        end
      end
      FILL: state_d = IDLE;
      MEM_WR_REQ: begin
        if (bus.mem_req_ready) begin
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = 1'b0;
    c_addr             = addr_q;
    c_wdata            = data_q;
    c_we               = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cpu_req_ready = 1'b1;
        c_addr            = bus.cpu_addr;
        c_wdata           = bus.cpu_wdata;
        c_we              = accept && bus.cpu_req_we;
      end
      MEM_RD_REQ: begin
        bus.mem_req_valid = 1'b1;
      end
      FILL: begin
        c_we               = 1'b1;
        bus.cpu_resp_valid = 1'b1;
      end
      MEM_WR_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
      end
      RESP: begin
        bus.cpu_resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  sat_counter #(.W(32)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ld_hit),
    .count (hit_count)
  );

  sat_counter #(.W(32)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ld_miss),
    .count (miss_count)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: cache RAM, memory model and a
// transaction-level reference checked every cycle.
module tb_dcache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_we, c_hit;
  logic [31:0] hit_count, miss_count;

  dcache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_we       (c_we),
    .c_rdata    (c_rdata),
    .c_hit      (c_hit),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // direct-mapped cache RAM, 256 words indexed by addr[9:2]
  logic [31:0]  cr_data [256];
  logic [31:0]  cr_tag  [256];
  logic [255:0] cr_vld;

  assign c_hit   = cr_vld[c_addr[9:2]] && (cr_tag[c_addr[9:2]] == c_addr);
  assign c_rdata = cr_data[c_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      cr_vld <= '0;
    end else if (c_we) begin
      cr_vld[c_addr[9:2]]  <= 1'b1;
      cr_tag[c_addr[9:2]]  <= c_addr;
      cr_data[c_addr[9:2]] <= c_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_tag [int];
  mop_t        exp_mop [$];

  int  cfg_rdy = 0;
  int  cfg_rsp = 0;
  bit  cfg_rand = 0;
  bit  sat_arm = 0;
  bit  sat_done = 0;
  bit  loaded = 0;

  int          cyc = 0;
  int          n_resp = 0;
  bit          outst = 0;
  bit          exp_miss = 0;
  int          due_cyc = -1;
  logic [31:0] exp_addr, exp_data;
  logic [31:0] ref_hit = '0;
  logic [31:0] ref_miss = '0;

  bit          m_busy = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_wait = 0;
  bit          rd_pend = 0;
  int          rd_wait = 0;
  logic [31:0] rd_addr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    logic        acc, st_acc, fill_now;
    logic [31:0] a, d;
    int          idx;
    mop_t        op;
    cyc++;
    if (!loaded) begin
      for (int i = 0; i < 512; i++) begin
        d = $urandom;
        mem_arr[32'(i * 4)] = d;
        ref_mem[32'(i * 4)] = d;
      end
      mem_arr[32'h200] = 32'h1234_5678;
      ref_mem[32'h200] = 32'h1234_5678;
      loaded = 1;
    end
    if (rst) begin
      check("rst_no_resp", {31'b0, bus.cpu_resp_valid}, 32'd0);
      outst    = 0;
      exp_miss = 0;
      due_cyc  = -1;
      exp_mop.delete();
      ref_tag.delete();
      m_busy   = 0;
      rd_pend  = 0;
      ref_hit  = '0;
      ref_miss = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
    end else begin
      if (sat_arm && !sat_done) begin
        ref_hit  = 32'hFFFF_FFFF;
        sat_done = 1;
      end
      check("hit_count", hit_count, ref_hit);
      check("miss_count", miss_count, ref_miss);
      check("cpu_req_ready", {31'b0, bus.cpu_req_ready}, {31'b0, !outst});

      acc      = bus.cpu_req_valid && bus.cpu_req_ready;
      st_acc   = acc && bus.cpu_req_we;
      fill_now = outst && exp_miss && (due_cyc == cyc);
      check("c_we", {31'b0, c_we}, {31'b0, st_acc || fill_now});

      if (bus.cpu_resp_valid) begin
        if (!outst) begin
          check("resp_unexp", {31'b0, bus.cpu_resp_valid}, 32'd0);
        end else begin
          check("resp_data", bus.cpu_rdata, exp_data);
          check("resp_cycle", cyc, due_cyc);
          if (exp_miss) begin
            check("fill_addr", c_addr, exp_addr);
            check("fill_wdata", c_wdata, exp_data);
            ref_tag[int'(exp_addr[9:2])] = exp_addr;
          end
          outst = 0;
          n_resp++;
        end
      end else if (outst && (due_cyc == cyc)) begin
        check("resp_missing", {31'b0, bus.cpu_resp_valid}, 32'd1);
      end

      if (acc) begin
        a   = bus.cpu_addr;
        idx = int'(a[9:2]);
        check("c_addr_idle", c_addr, a);
        outst    = 1;
        exp_addr = a;
        exp_miss = 0;
        due_cyc  = -1;
        if (bus.cpu_req_we) begin
          check("st_wdata", c_wdata, bus.cpu_wdata);
          ref_mem[a]   = bus.cpu_wdata;
          ref_tag[idx] = a;
          exp_data     = '0;
          exp_mop.push_back('{1'b1, a, bus.cpu_wdata});
        end else if (ref_tag.exists(idx) && ref_tag[idx] == a) begin
          exp_data = ref_rd(a);
          due_cyc  = cyc + 1;
          if (ref_hit != 32'hFFFF_FFFF) ref_hit++;
        end else begin
          exp_miss = 1;
          exp_data = ref_rd(a);
          if (ref_miss != 32'hFFFF_FFFF) ref_miss++;
          exp_mop.push_back('{1'b0, a, 32'h0});
        end
      end

      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = mem_rd(rd_addr);
          rd_pend            = 0;
          due_cyc            = cyc + 1;
        end else begin
          rd_wait--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // stray response outside the wait state must be ignored
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = $urandom;
      end

      if (bus.mem_req_valid) begin
        if (!m_busy) begin
          m_busy  = 1;
          m_addr  = bus.mem_addr;
          m_we    = bus.mem_req_we;
          m_wdata = bus.mem_wdata;
          m_wait  = cfg_rand ? int'($urandom_range(0, 4)) : cfg_rdy;
          if (exp_mop.size() == 0) begin
            check("mem_req_unexp", {31'b0, bus.mem_req_valid}, 32'd0);
          end else begin
            op = exp_mop.pop_front();
            check("mem_we", {31'b0, m_we}, {31'b0, op.we});
            check("mem_addr", m_addr, op.addr);
            if (op.we) check("mem_wdata", m_wdata, op.data);
          end
        end
        if (m_wait == 0) begin
          check("mem_hold_addr", bus.mem_addr, m_addr);
          check("mem_hold_we", {31'b0, bus.mem_req_we}, {31'b0, m_we});
          if (m_we) check("mem_hold_wdata", bus.mem_wdata, m_wdata);
          bus.mem_req_ready = 1'b1;
          m_busy = 0;
          if (m_we) begin
            mem_arr[m_addr] = m_wdata;
            due_cyc = cyc + 1;
          end else begin
            rd_pend = 1;
            rd_addr = m_addr;
            rd_wait = cfg_rand ? int'($urandom_range(0, 4)) : cfg_rsp;
          end
        end else begin
          m_wait--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mem_req_ready = 1'b1;
      end
    end
  end

  // called just after a rising edge; returns just after the accept edge
  task automatic cpu_op(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    int n;
    n = 0;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_addr      = a;
    bus.cpu_wdata     = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_req_ready && n < 200);
    if (n >= 200) check("accept_timeout", {31'b0, bus.cpu_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (outst && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", {31'b0, bus.cpu_req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [31:0] a;
    bit hold;
    rst               = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, bus.cpu_req_ready}, 32'd1);
    check("reset_rdata", bus.cpu_rdata, 32'd0);
    check("reset_memv", {31'b0, bus.mem_req_valid}, 32'd0);
    @(posedge clk);
    #1;

    cpu_op(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    wait_idle();
    cpu_op(1'b0, 32'h100, 32'h0, 1'b0);
    wait_idle();
    check("hit_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    check("hit_count1", hit_count, 32'd1);

    cfg_rsp = 3;
    cpu_op(1'b0, 32'h200, 32'h0, 1'b0);
    wait_idle();
    check("miss_rdata", bus.cpu_rdata, 32'h1234_5678);
    check("miss_count1", miss_count, 32'd1);
    cpu_op(1'b0, 32'h200, 32'h0, 1'b0);
    wait_idle();
    check("rehit_count", hit_count, 32'd2);

    cfg_rsp = 0;
    cfg_rdy = 4;
    cpu_op(1'b1, 32'h300, 32'hA5A5_A5A5, 1'b0);
    wait_idle();
    check("st_ack_rdata", bus.cpu_rdata, 32'd0);
    cfg_rdy = 0;
    cpu_op(1'b0, 32'h300, 32'h0, 1'b0);
    wait_idle();
    check("st_then_hit", hit_count, 32'd3);
    check("st_hit_rdata", bus.cpu_rdata, 32'hA5A5_A5A5);

    n0 = n_resp;
    cpu_op(1'b0, 32'h100, 32'h0, 1'b1);
    cpu_op(1'b0, 32'h600, 32'h0, 1'b1);
    cpu_op(1'b0, 32'h300, 32'h0, 1'b0);
    wait_idle();
    check("b2b_resps", n_resp - n0, 32'd3);

    cfg_rand = 1;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 1) << 10) | ($urandom_range(0, 15) << 2);
      hold = (i != 299) && ($urandom_range(0, 1) == 1);
      cpu_op($urandom_range(0, 3) == 0, a, $urandom, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    cfg_rand = 0;

    cfg_rsp = 20;
    n0 = n_resp;
    cpu_op(1'b0, 32'h1000, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, bus.cpu_req_ready}, 32'd1);
    check("rst_mid_hits", hit_count, 32'd0);
    check("rst_mid_miss", miss_count, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_noresp", n_resp - n0, 32'd0);
    cfg_rsp = 0;

    cpu_op(1'b1, 32'h100, 32'h5555_0001, 1'b0);
    wait_idle();
    force dut.u_hit_cnt.count_q = 32'hFFFF_FFFF;
    sat_arm = 1;
    @(posedge clk);
    #1;
    release dut.u_hit_cnt.count_q;
    @(posedge clk);
    #1;
    cpu_op(1'b0, 32'h100, 32'h0, 1'b0);
    wait_idle();
    check("hit_sat", hit_count, 32'hFFFF_FFFF);
    check("hit_sat_rdata", bus.cpu_rdata, 32'h5555_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL take clock clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL take reset rst, input, 1 bit: synchronous, active-high.
REQ-003 SHALL take cpu_req_valid, cpu_req_we (1=store), cpu_addr[31:0], cpu_wdata[31:0] as CPU-side inputs.
REQ-004 SHALL drive cpu_req_ready (1), cpu_resp_valid (1) and cpu_rdata[31:0] as CPU-side outputs.
REQ-005 SHALL drive c_addr[31:0], c_wdata[31:0] and c_we (1) to the cache, and take c_rdata[31:0] and c_hit (1) from it; cache lookup is combinational, same cycle.
REQ-006 SHALL drive mem_req_valid, mem_req_we, mem_addr[31:0] and mem_wdata[31:0]; SHALL take mem_req_ready, mem_resp_valid and mem_rdata[31:0].
REQ-007 SHALL drive hit_count[31:0] and miss_count[31:0] as outputs, both load-only.

Function
REQ-008 SHALL use states IDLE, MEM_RD_REQ, MEM_RD_WAIT, FILL, MEM_WR_REQ, RESP.
REQ-009 cpu_req_ready SHALL be 1 only in IDLE; a request is accepted when cpu_req_valid && cpu_req_ready.
REQ-010 In IDLE, c_addr SHALL equal cpu_addr; in all other states, c_addr SHALL equal the address latched at accept.
REQ-011 c_we SHALL be 0 except (a) on the store-accept cycle and (b) the single FILL cycle.
REQ-012 Load hit (accepted, !cpu_req_we, c_hit): latch c_rdata, go to RESP; cpu_resp_valid SHALL pulse the next cycle with that data (1-cycle latency); then go to IDLE.
REQ-013 Load miss: latch the address, go to MEM_RD_REQ.
REQ-014 MEM_RD_REQ: drive mem_req_valid=1, mem_req_we=0, mem_addr=latched address, held stable until mem_req_ready; then go to MEM_RD_WAIT.
REQ-015 MEM_RD_WAIT: on mem_resp_valid, latch mem_rdata and go to FILL.
REQ-016 FILL (one cycle): c_we=1, c_wdata=the latched fill data; cpu_resp_valid=1 with cpu_rdata=the fill data; next state IDLE.
REQ-017 Store: on the accept cycle, c_we=1 and c_wdata=cpu_wdata (write-through, write-allocate); latch address and data, go to MEM_WR_REQ.
REQ-018 MEM_WR_REQ: mem_req_valid=1, mem_req_we=1, address and data stable until mem_req_ready; then go to RESP, which pulses cpu_resp_valid (write ack; cpu_rdata=0).
REQ-019 cpu_resp_valid SHALL be a single-cycle pulse with no backpressure; cpu_rdata SHALL hold its value until the next response.
REQ-020 mem_resp_valid outside MEM_RD_WAIT SHALL be ignored; mem_req_ready outside the REQ states SHALL be ignored.
REQ-021 mem_req_valid SHALL be 0 in IDLE, MEM_RD_WAIT, FILL and RESP.
REQ-022 hit_count SHALL increment once per accepted load hit; miss_count SHALL increment once per accepted load miss; both saturate at 32'hFFFF_FFFF.
REQ-023 Miss latency SHALL be: cycles until mem_req_ready + cycles until mem_resp_valid + 1 (the FILL cycle).

Reset
REQ-024 On rst: state=IDLE; cpu_resp_valid, mem_req_valid, c_we=0; cpu_rdata, latches and counters=0; cpu_req_ready=1 from the first non-reset cycle.
REQ-025 rst mid-transaction SHALL abandon the transaction with no response; rst is shared with the memory so no stale response follows.

Structure
REQ-026 The state enum, ADDR_W=32 and DATA_W=32 SHALL live in the shared package cache_pkg.
REQ-027 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.
REQ-028 The FSM SHALL use a registered state and combinational next-state/output logic; c_addr, c_we and c_wdata SHALL be combinational.

Verification
REQ-029 Load hit: preload 0x100=0xDEAD_BEEF, then load 0x100 -> cpu_resp_valid the next cycle with 0xDEAD_BEEF, mem_req_valid never 1, hit_count=1.
REQ-030 Load miss, memory latency 3: load 0x200 (mem holds 0x1234_5678) -> one mem read at 0x200, FILL writes 0x1234_5678 with c_we=1, response in the FILL cycle, miss_count=1; a re-load hits with 1-cycle latency.
REQ-031 Store 0x300=0xA5A5_A5A5 with mem_req_ready delayed 4 cycles -> c_we on the accept cycle only, mem request stable for 4 cycles, ack one cycle after ready, and a subsequent load of 0x300 hits.
REQ-032 Back-to-back: cpu_req_valid held high for 3 loads -> cpu_req_ready=0 outside IDLE, exactly 3 responses in order.
REQ-033 rst asserted in MEM_RD_WAIT -> no cpu_resp_valid, state IDLE, counters 0, cpu_req_ready=1 on the next cycle.
REQ-034 Force hit_count to 32'hFFFF_FFFF and perform a load hit -> hit_count stays 32'hFFFF_FFFF.
